// File: rtl/multibyte_add_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision add/subtract sequencer.
// Holds the FSM encoding, operation-select values and the adder slice width.
package multibyte_add_seq_pkg;

  localparam int   BYTE_W = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/multibyte_add_seq_cla.sv
// 8-bit carry-lookahead adder slice; purely combinational, zero latency, no flow control.
// Every carry is a flat sum-of-products of generate/propagate terms and the carry-in.
module eightbitCLA
  import multibyte_add_seq_pkg::*;
(
  output logic [BYTE_W-1:0] sum,
  output logic              carryout,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carryin
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              run_p;
  logic              cc;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]carryin, built from the top bit downwards
  always_comb begin
    c     = '0;
    run_p = 1'b1;
    cc    = 1'b0;
    c[0]  = carryin;
    for (int i = 0; i < BYTE_W; i++) begin
      run_p = 1'b1;
      cc    = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc    = cc | (g[j] & run_p);
        run_p = run_p & p[j];
      end
      c[i+1] = cc | (run_p & carryin);
    end
  end

  assign sum      = p ^ c[BYTE_W-1:0];
  assign carryout = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Multi-precision add/subtract, one byte per clock LSB first; valid WORDS cycles after accept.
// New requests are refused (ready low) until the held result is acknowledged.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int IDXW  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sub,
  input  logic [BYTE_W*WORDS-1:0] opa,
  input  logic [BYTE_W*WORDS-1:0] opb,
  output logic                    ready,
  output logic                    valid,
  input  logic                    ack,
  output logic [BYTE_W*WORDS-1:0] result,
  output logic                    carryout,
  output logic                    overflow
);

  state_t state;
  state_t state_nxt;

  logic [IDXW-1:0]                idx;
  logic                           carry_q;
  logic                           sub_q;
  logic [WORDS-1:0][BYTE_W-1:0]   a_q;
  logic [WORDS-1:0][BYTE_W-1:0]   b_q;
  logic [WORDS-1:0][BYTE_W-1:0]   res_q;
  logic                           co_q;
  logic                           ovf_q;

  logic [BYTE_W-1:0]              cla_a;
  logic [BYTE_W-1:0]              cla_b;
  logic [BYTE_W-1:0]              cla_sum;
  logic                           cla_co;
  logic                           last;

  assign last  = (idx == IDXW'(WORDS - 1));
  assign cla_a = a_q[idx];
  // Subtraction is A + ~B + 1; the +1 enters through the carry register seeded at accept.
  assign cla_b = (sub_q == OP_ADD) ? b_q[idx] : ~b_q[idx];

  eightbitCLA u_cla (
    .sum      (cla_sum),
    .carryout (cla_co),
    .a        (cla_a),
    .b        (cla_b),
    .carryin  (carry_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = HOLD;
      HOLD:    if (ack)   state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= opa;
            b_q     <= opb;
            sub_q   <= sub;
            carry_q <= (sub == OP_SUB);
            idx     <= '0;
          end
        end
        RUN: begin
          res_q[idx] <= cla_sum;
          carry_q    <= cla_co;
          if (last) begin
            co_q  <= cla_co;
            ovf_q <= (cla_a[BYTE_W-1] == cla_b[BYTE_W-1]) &&
                     (cla_sum[BYTE_W-1] != cla_a[BYTE_W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == IDLE);
  assign valid    = (state == HOLD);
  assign result   = res_q;
  assign carryout = co_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq at WORDS=4 with hand-computed vectors.
module tb_multibyte_add_seq;

  localparam int WORDS = 4;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 sub;
  logic [8*WORDS-1:0]   opa;
  logic [8*WORDS-1:0]   opb;
  logic                 ready;
  logic                 valid;
  logic                 ack;
  logic [8*WORDS-1:0]   result;
  logic                 carryout;
  logic                 overflow;

  int n_assert;
  int n_fail;

  multibyte_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .opa      (opa),
    .opb      (opb),
    .ready    (ready),
    .valid    (valid),
    .ack      (ack),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it cycle by cycle to the held result.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eco, input logic eov, input logic ackv);
    @(negedge clk);
    sub = s; opa = a; opb = b; start = 1'b1; ack = ackv;
    chk({tag, "_ready_pre"}, ready, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_ready_busy"}, ready, 1'b0);
    chk({tag, "_valid_early"}, valid, 1'b0);
    for (int k = 1; k <= WORDS; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_valid_c%0d", tag, k), valid, (k == WORDS));
    end
    chk({tag, "_result"}, result, er);
    chk({tag, "_carryout"}, carryout, eco);
    chk({tag, "_overflow"}, overflow, eov);
    if (ackv) begin
      @(posedge clk); #1;
      chk({tag, "_ready_back"}, ready, 1'b1);
      chk({tag, "_valid_drop"}, valid, 1'b0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; ack = 1'b0; opa = '0; opb = '0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_carryout", carryout, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    run_op("sub_brw",  1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    run_op("sub_eq",   1'b1, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_mix",  1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Held result must survive a stalled consumer and a stray request.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 4);
      if (c == 4) begin opa = 32'h0000_0001; opb = 32'h0000_0001; sub = 1'b0; end
      @(posedge clk); #1;
      chk($sformatf("hold_valid_c%0d", c), valid, 1'b1);
      chk($sformatf("hold_result_c%0d", c), result, 32'h2345_6789);
    end
    @(negedge clk);
    start = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    chk("hold_ack_ready", ready, 1'b1);
    chk("hold_ack_valid", valid, 1'b0);
    @(posedge clk); #1;
    chk("no_second_op", ready, 1'b1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    sub = 1'b0; opa = 32'h0102_0304; opb = 32'h0101_0101; start = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_valid", valid, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_carryout", carryout, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("arst_quiet_valid_c%0d", c), valid, 1'b0);
    end
    run_op("post_rst", 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
Multi-precision add/subtract sequencer. It time-shares a single 8-bit carry-lookahead adder across WORDS bytes, one byte per clock, least-significant byte first. Carry is chained between beats through a register. The block sits between a requesting controller (start/ready handshake) and a consumer (valid/ack handshake).

Parameters:
WORDS, 4, number of bytes per operand; legal range 2..16
IDXW, $clog2(WORDS), width of the byte-index counter (derived; do not override)

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  request; accepted only when Ready=1
Sub    input  1  operation select, sampled with Start: 0 = A+B, 1 = A-B
OpA    input  8*WORDS  operand A, sampled with Start
OpB    input  8*WORDS  operand B, sampled with Start
Ready  output 1  high in IDLE only
Valid  output 1  result available; held until Ack
Ack    input  1  consumer accepts the result; meaningful only while Valid=1
Result output 8*WORDS  sum or difference
Carryout output 1  final carry out of the MSB; for Sub, 1 = no borrow (A >= B unsigned)
Overflow output 1  two's-complement signed overflow of the full-width operation

Behaviour:
- FSM states: IDLE, RUN, HOLD. Reset value: IDLE.
- Reset (asynchronous, any state, including mid-RUN):
  - Ready=1; Valid, Result, Carryout, Overflow = 0.
  - Byte index, carry register and operand registers cleared.
  - An in-flight operation is discarded; no Valid is produced for it.
- IDLE: Start=1 at an edge:
  - latch OpA, OpB, Sub;
  - carry register := Sub; index := 0;
  - go to RUN. Ready falls on the same edge.
- RUN, each edge:
  - adder inputs: A = A_reg[idx], B = B_reg[idx] XOR {8{Sub_reg}}, Carryin = carry register;
  - Result[idx] := Sum; carry register := adder Carryout; idx := idx+1;
  - when idx == WORDS-1: Carryout := adder Carryout, Overflow computed (see below), go to HOLD.
- Latency: Valid rises exactly WORDS edges after the Start-accept edge (e.g. WORDS=4: 4 cycles).
- Overflow = (A_msb == B'_msb) AND (Sum_msb != A_msb), where B' is the inverted B when Sub=1.
- HOLD:
  - Valid=1; Result, Carryout and Overflow are stable.
  - Ack=1 at an edge: Valid falls, Ready rises, go to IDLE.
- Ignored inputs:
  - Start in RUN or HOLD is ignored; no queueing.
  - Start and Ack together in HOLD: Ack is taken, Start is ignored, so the requester re-issues in IDLE.
  - Ack outside HOLD is ignored.
- Result is defined only while Valid=1. During RUN, the bytes not yet written keep their previous values.
- Index counter never wraps in normal operation: it is cleared on accept, and RUN exits at WORDS-1.
- Widths: all adder datapaths are 8 bits; the carry register is 1 bit; no other arithmetic on operands.

Decomposition:
- Shared package:
  - FSM state enumeration (IDLE/RUN/HOLD, 2-bit encoding);
  - operation-select constants OP_ADD=0, OP_SUB=1;
  - BYTE_W=8.
- One sub-module: eightbitCLA, the team's existing 8-bit carry-lookahead adder.
  - Ports: Sum, Carryout, A, B, Carryin.
  - Instantiated once; all sequencing lives in multibyte_add_seq.

Test Plan:
- WORDS=4, Sub=0, OpA=0xFFFFFFFF, OpB=0x00000001, Ack held high -> Valid exactly 4 cycles after accept; Result=0x00000000, Carryout=1, Overflow=0; Ready 1 cycle later.
- Sub=0, OpA=0x7FFFFFFF, OpB=0x00000001 -> Result=0x80000000, Carryout=0, Overflow=1.
- Sub=1, OpA=0x00000005, OpB=0x00000007 -> Result=0xFFFFFFFE, Carryout=0 (borrow), Overflow=0.
- Sub=1, OpA=0x80000000, OpB=0x00000001 -> Result=0x7FFFFFFF, Carryout=1, Overflow=1.
- Ack low 10 cycles in HOLD, Start pulsed with new operands mid-HOLD -> Valid stays 1, Result unchanged; Ack then returns to IDLE with no second operation started.
- Reset asserted asynchronously after 2 RUN cycles -> Valid/Result/Carryout/Overflow=0, Ready=1 immediately; next Start of 0x00000010+0x00000020 gives Result=0x00000030 with normal 4-cycle latency.
